// File: rtl/fixed_point_max_of_4.sv
// Maximum of four fixed-point scores ahead of the softmax max(x)-x stage.
// Two time-shared comparators: both in CMP1, the first reused for the final compare in CMP2.
module fixed_point_max_of_4 #(
  parameter int unsigned ARITH_TYPE = 1,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned INTEGER    = 16,
  parameter int unsigned FRACTION   = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in1,
  input  logic [DATA_WIDTH-1:0] in2,
  input  logic [DATA_WIDTH-1:0] in3,
  input  logic [DATA_WIDTH-1:0] in4,
  output logic [DATA_WIDTH-1:0] out1,
  output logic [DATA_WIDTH-1:0] out2,
  output logic [DATA_WIDTH-1:0] out3,
  output logic [DATA_WIDTH-1:0] out4,
  output logic [DATA_WIDTH-1:0] max_input,
  output logic                  softmax_enable,
  output logic                  busy
);

  if (INTEGER + FRACTION != DATA_WIDTH) begin : g_fmt_check
    $error("INTEGER + FRACTION must equal DATA_WIDTH");
  end

  typedef enum logic [1:0] {StIdle, StCmp1, StCmp2, StDone} state_e;

  state_e                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   m12_q, m34_q;
  logic [DATA_WIDTH-1:0]   cmp_a_x, cmp_a_y, max_a, max_b;

  function automatic logic greater(input logic [DATA_WIDTH-1:0] a,
                                   input logic [DATA_WIDTH-1:0] b);
    if (ARITH_TYPE != 0) return $signed(a) > $signed(b);
    else                 return a > b;
  endfunction

  always_comb begin
    state_d  = state_q;
    in_ready = (state_q == StIdle);
    busy     = (state_q != StIdle);
    unique case (state_q)
      StIdle:  if (in_valid) state_d = StCmp1;
      StCmp1:  state_d = StCmp2;
      StCmp2:  state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Comparator A sees the raw pair in CMP1 and the two partial maxima in CMP2.
  always_comb begin
    cmp_a_x = (state_q == StCmp2) ? m12_q : out1;
    cmp_a_y = (state_q == StCmp2) ? m34_q : out2;
    max_a   = greater(cmp_a_x, cmp_a_y) ? cmp_a_x : cmp_a_y;
    max_b   = greater(out3, out4) ? out3 : out4;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= StIdle;
      out1           <= '0;
      out2           <= '0;
      out3           <= '0;
      out4           <= '0;
      m12_q          <= '0;
      m34_q          <= '0;
      max_input      <= '0;
      softmax_enable <= 1'b0;
    end else begin
      state_q        <= state_d;
      softmax_enable <= (state_q == StCmp2);
      if (state_q == StIdle && in_valid) begin
        out1 <= in1;
        out2 <= in2;
        out3 <= in3;
        out4 <= in4;
      end
      if (state_q == StCmp1) begin
        m12_q <= max_a;
        m34_q <= max_b;
      end
      if (state_q == StCmp2) max_input <= max_a;
    end
  end

endmodule

// File: tb/tb_fixed_point_max_of_4.sv
// Scoreboarded bench driving a signed and an unsigned instance with identical stimulus.
module tb_fixed_point_max_of_4;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic [W-1:0] in1, in2, in3, in4;

  logic         s_ready, s_se, s_busy;
  logic [W-1:0] s_o1, s_o2, s_o3, s_o4, s_max;
  logic         u_ready, u_se, u_busy;
  logic [W-1:0] u_o1, u_o2, u_o3, u_o4, u_max;

  fixed_point_max_of_4 #(.ARITH_TYPE(1), .DATA_WIDTH(W), .INTEGER(16), .FRACTION(16)) dut_s (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(s_ready),
    .in1(in1), .in2(in2), .in3(in3), .in4(in4),
    .out1(s_o1), .out2(s_o2), .out3(s_o3), .out4(s_o4),
    .max_input(s_max), .softmax_enable(s_se), .busy(s_busy)
  );

  fixed_point_max_of_4 #(.ARITH_TYPE(0), .DATA_WIDTH(W), .INTEGER(16), .FRACTION(16)) dut_u (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(u_ready),
    .in1(in1), .in2(in2), .in3(in3), .in4(in4),
    .out1(u_o1), .out2(u_o2), .out3(u_o3), .out4(u_o4),
    .max_input(u_max), .softmax_enable(u_se), .busy(u_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [W-1:0] o1, o2, o3, o4, ms, mu;
    int           due;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, required 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every enable pulse must match the oldest outstanding transaction.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (s_se || u_se) begin
        if (q.size() == 0) begin
          chk("unexpected_pulse", 32'(s_se | u_se), 32'd0);
        end else begin
          e = q.pop_front();
          chk("pulse_s", 32'(s_se), 32'd1);
          chk("pulse_u", 32'(u_se), 32'd1);
          chk("pulse_cycle", 32'(cyc), 32'(e.due));
          chk("out1", s_o1, e.o1);
          chk("out2", s_o2, e.o2);
          chk("out3", s_o3, e.o3);
          chk("out4", s_o4, e.o4);
          chk("u_out4", u_o4, e.o4);
          chk("max_signed", s_max, e.ms);
          chk("max_unsigned", u_max, e.mu);
        end
      end else if (q.size() != 0 && cyc > q[0].due) begin
        chk("missing_pulse", 32'(s_se), 32'd1);
        void'(q.pop_front());
      end
    end
  end

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c,
                      input logic [W-1:0] d, input logic [W-1:0] ms, input logic [W-1:0] mu);
    int n = 0;
    @(posedge clk); #1;
    in1 = a; in2 = b; in3 = c; in4 = d;
    in_valid = 1'b1;
    @(negedge clk);
    while (!s_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!s_ready) chk("accept_timeout", 32'(s_ready), 32'd1);
    else          q.push_back('{a, b, c, d, ms, mu, cyc + 3});
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int last;
    int n;
    reset = 1'b1;
    in_valid = 1'b0;
    in1 = '0; in2 = '0; in3 = '0; in4 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out1", s_o1, 32'h0);
    chk("rst_out4", s_o4, 32'h0);
    chk("rst_max", s_max, 32'h0);
    chk("rst_enable", 32'(s_se), 32'd0);
    chk("rst_busy", 32'(s_busy), 32'd0);
    chk("rst_ready", 32'(s_ready), 32'd1);
    @(negedge clk);
    reset = 1'b0;

    // Basic mixed-sign vector; signed and unsigned maxima differ.
    send(32'h0001_0000, 32'h0003_8000, 32'hFFFF_0000, 32'h0002_0000, 32'h0003_8000, 32'hFFFF_0000);
    chk("busy_after_accept", 32'(s_busy), 32'd1);
    chk("ready_after_accept", 32'(s_ready), 32'd0);
    // All negative.
    send(32'hFFFE_0000, 32'hFFFF_8000, 32'hFFF0_0000, 32'h8000_0000, 32'hFFFF_8000, 32'hFFFF_8000);
    // Sign boundary 0x8000_0000 vs 0x7FFF_FFFF.
    send(32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 32'h8000_0000);
    // Maximum from the second pair.
    send(32'h0000_0001, 32'h0000_0002, 32'h0000_0003, 32'h0000_0004, 32'h0000_0004, 32'h0000_0004);
    send(32'h0000_0010, 32'h0000_0020, 32'h7FFF_0000, 32'h8000_0000, 32'h7FFF_0000, 32'h8000_0000);

    // Ties with in_valid held high: one accept every 4 cycles.
    @(posedge clk); #1;
    in1 = 32'h0005_0000; in2 = 32'h0005_0000; in3 = 32'h0005_0000; in4 = 32'h0005_0000;
    in_valid = 1'b1;
    acc = 0;
    last = -1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (s_ready) begin
        q.push_back('{in1, in2, in3, in4, 32'h0005_0000, 32'h0005_0000, cyc + 3});
        if (last >= 0) chk("b2b_gap", 32'(cyc - last), 32'd4);
        last = cyc;
        acc++;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("b2b_accepts", 32'(acc), 32'd4);
    repeat (4) @(posedge clk);

    // in_valid with different data while busy must be ignored.
    send(32'h0000_1111, 32'h0000_2222, 32'h0000_3333, 32'h0000_4444, 32'h0000_4444, 32'h0000_4444);
    in1 = 32'hDEAD_0000; in2 = 32'h7EEF_0000; in3 = 32'h7000_0000; in4 = 32'h6000_0000;
    in_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("ignored_out1", s_o1, 32'h0000_1111);
    chk("ignored_out4", s_o4, 32'h0000_4444);
    chk("ignored_max", s_max, 32'h0000_4444);

    // Reset while in CMP2: no pulse for the aborted transaction.
    @(posedge clk); #1;
    in1 = 32'h0009_0000; in2 = 32'h0001_0000; in3 = 32'h0002_0000; in4 = 32'h0003_0000;
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!s_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("abort_accept", 32'(s_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("abort_in_cmp2_busy", 32'(s_busy), 32'd1);
    reset = 1'b1;
    #1;
    chk("abort_busy", 32'(s_busy), 32'd0);
    chk("abort_ready", 32'(s_ready), 32'd1);
    chk("abort_out1", s_o1, 32'h0);
    chk("abort_max", s_max, 32'h0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("abort_enable", 32'(s_se), 32'd0);
    repeat (4) @(negedge clk);
    chk("abort_ready_idle", 32'(s_ready), 32'd1);

    send(32'hFFFF_FFFF, 32'h0000_0000, 32'h0001_0000, 32'h0000_8000, 32'h0001_0000, 32'hFFFF_FFFF);
    repeat (6) @(posedge clk);
    #1;
    chk("queue_drained", 32'(q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
